// File: rtl/serv_dbus_ctrl.sv
// rtl/serv_dbus_ctrl.sv - Wishbone classic data-bus master for the load/store buffer.
// Optional bus timeout abort is enabled by defining SERV_DBUS_TIMEOUT_EN.
module serv_dbus_ctrl #(
  parameter int TIMEOUT_W = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_dbus_req,
  input  logic        i_wen,
  input  logic [31:0] i_adr,
  input  logic        i_word,
  input  logic        i_half,
  input  logic [31:0] i_dat,
  output logic        o_dbus_ack,
  output logic        o_err,
  output logic        o_load,
  output logic [31:0] o_rdt,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] rdt_q, rdt_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic        misalign;
  logic [3:0]  sel_req;
  logic        timeout;
  logic        resp;

  always_comb begin
    misalign = (i_half & i_adr[0]) | (i_word & (i_adr[1:0] != 2'b00));
    if (i_word)
      sel_req = 4'b1111;
    else if (i_half)
      sel_req = i_adr[1] ? 4'b1100 : 4'b0011;
    else
      sel_req = 4'b0001 << i_adr[1:0];
  end

`ifdef SERV_DBUS_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d, tmo_inc;

  // Held at zero while idle so every bus cycle starts counting from zero.
  always_comb begin
    tmo_inc = tmo_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    tmo_d   = tmo_q;
    if (state_q == S_IDLE)
      tmo_d = '0;
    else if (state_q == S_BUS)
      tmo_d = tmo_inc;
  end

  assign timeout = (state_q == S_BUS) && (&tmo_inc);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      tmo_q <= '0;
    else
      tmo_q <= tmo_d;
  end
`else
  assign timeout = 1'b0 & (TIMEOUT_W != 0);
`endif

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdt_d   = rdt_q;
    sel_d   = sel_q;
    we_d    = we_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (i_dbus_req) begin
          adr_d   = {i_adr[31:2], 2'b00};
          dat_d   = i_dat;
          we_d    = i_wen;
          sel_d   = sel_req;
          err_d   = misalign;
          state_d = misalign ? S_RESP : S_BUS;
        end
      end
      S_BUS: begin
        // An ack arriving together with the final count takes priority.
        if (i_wb_ack) begin
          if (!we_q)
            rdt_d = i_wb_rdt;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      rdt_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdt_q   <= rdt_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  assign resp       = (state_q == S_RESP);
  assign o_wb_cyc   = (state_q == S_BUS);
  assign o_dbus_ack = resp;
  assign o_err      = resp & err_q;
  assign o_load     = resp & ~we_q & ~err_q;
  assign o_rdt      = rdt_q;
  assign o_wb_adr   = adr_q;
  assign o_wb_dat   = dat_q;
  assign o_wb_sel   = sel_q;
  assign o_wb_we    = we_q;

endmodule
